// File: rtl/mem_wb_stage.sv
// MIPS write-back stage: MEM/WB register, sub-word load extract/extend, RF write port, forward source.
// One-cycle latency; Stall holds, Flush bubbles. Optional RetireCount under `ifdef RETIRE_CNT_EN.
module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic [DATA_W-1:0] MemoryRead_in,
    input  logic [DATA_W-1:0] ALUResult_in,
    input  logic [REG_AW-1:0] AddressSelected_in,
    input  logic              RegWrite_in,
    input  logic              MemToReg_in,
    input  logic [1:0]        BitSel_in,
    input  logic              LoadUnsigned_in,
`ifdef RETIRE_CNT_EN
    output logic [31:0]       RetireCount,
`endif
    output logic [DATA_W-1:0] WriteData,
    output logic [REG_AW-1:0] WriteReg,
    output logic              RegWrite_wb,
    output logic              Fwd_Valid,
    output logic [REG_AW-1:0] Fwd_Reg
);

    logic [DATA_W-1:0] r_mem_read;
    logic [DATA_W-1:0] r_alu_result;
    logic [REG_AW-1:0] r_addr_sel;
    logic              r_reg_write;
    logic              r_mem_to_reg;
    logic [1:0]        r_bit_sel;
    logic              r_load_unsigned;

    always_ff @(posedge Clk) begin
        if (!Rst_n || Flush) begin
            r_mem_read      <= '0;
            r_alu_result    <= '0;
            r_addr_sel      <= '0;
            r_reg_write     <= 1'b0;
            r_mem_to_reg    <= 1'b0;
            r_bit_sel       <= 2'b00;
            r_load_unsigned <= 1'b0;
        end else if (!Stall) begin
            r_mem_read      <= MemoryRead_in;
            r_alu_result    <= ALUResult_in;
            r_addr_sel      <= AddressSelected_in;
            r_reg_write     <= RegWrite_in;
            r_mem_to_reg    <= MemToReg_in;
            r_bit_sel       <= BitSel_in;
            r_load_unsigned <= LoadUnsigned_in;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge Clk) begin
        if (!Rst_n)
            r_retire_cnt <= '0;
        else if (!Flush && !Stall && RegWrite_in)
            r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign RetireCount = r_retire_cnt;
`endif

    logic [1:0]        w_off;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic              w_sx;

    assign w_off = r_alu_result[1:0];
    assign w_sx  = ~r_load_unsigned;

    always_comb begin
        w_byte = r_mem_read[7:0];
        case (w_off)
            2'd0: w_byte = r_mem_read[7:0];
            2'd1: w_byte = r_mem_read[15:8];
            2'd2: w_byte = r_mem_read[23:16];
            2'd3: w_byte = r_mem_read[31:24];
            default: w_byte = r_mem_read[7:0];
        endcase
    end

    // Half-word lane ignores off[0]: misaligned halves read the containing half.
    assign w_half = w_off[1] ? r_mem_read[31:16] : r_mem_read[15:0];

    always_comb begin
        w_load = r_mem_read;
        case (r_bit_sel)
            2'b01:   w_load = {{(DATA_W-16){w_half[15] & w_sx}}, w_half};
            2'b10:   w_load = {{(DATA_W-8){w_byte[7] & w_sx}}, w_byte};
            default: w_load = r_mem_read;
        endcase
    end

    assign WriteData   = r_mem_to_reg ? w_load : r_alu_result;
    assign WriteReg    = r_addr_sel;
    assign RegWrite_wb = r_reg_write && (r_addr_sel != '0);
    assign Fwd_Valid   = RegWrite_wb;
    assign Fwd_Reg     = r_addr_sel;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: per-cycle model comparison plus literal spot checks.
module tb_mem_wb_stage;

    logic        Clk = 1'b0;
    logic        Rst_n, Stall, Flush;
    logic [31:0] MemoryRead_in, ALUResult_in;
    logic [4:0]  AddressSelected_in;
    logic        RegWrite_in, MemToReg_in, LoadUnsigned_in;
    logic [1:0]  BitSel_in;
    logic [31:0] WriteData;
    logic [4:0]  WriteReg, Fwd_Reg;
    logic        RegWrite_wb, Fwd_Valid;
`ifdef RETIRE_CNT_EN
    logic [31:0] RetireCount;
`endif

    mem_wb_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Flush(Flush),
        .MemoryRead_in(MemoryRead_in), .ALUResult_in(ALUResult_in),
        .AddressSelected_in(AddressSelected_in), .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in), .BitSel_in(BitSel_in),
        .LoadUnsigned_in(LoadUnsigned_in),
`ifdef RETIRE_CNT_EN
        .RetireCount(RetireCount),
`endif
        .WriteData(WriteData), .WriteReg(WriteReg), .RegWrite_wb(RegWrite_wb),
        .Fwd_Valid(Fwd_Valid), .Fwd_Reg(Fwd_Reg)
    );

    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    typedef struct {
        logic [31:0] mr, alu;
        logic [4:0]  a;
        logic        rw, m2r, lu;
        logic [1:0]  bs;
    } ent_t;

    ent_t        m;
    logic [31:0] m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Lane chosen by shifting the word by the byte/half offset, then extended arithmetically.
    function automatic logic [31:0] exp_wd(input ent_t e);
        logic [31:0] lane;
        int          w;
        if (!e.m2r) return e.alu;
        if (e.bs == 2'b10) begin
            lane = (e.mr >> (8 * e.alu[1:0])) & 32'h0000_00FF;
            w    = 8;
        end else if (e.bs == 2'b01) begin
            lane = (e.mr >> (16 * e.alu[1])) & 32'h0000_FFFF;
            w    = 16;
        end else begin
            return e.mr;
        end
        if (!e.lu && lane[w-1]) lane = lane | (32'hFFFF_FFFF << w);
        return lane;
    endfunction

    always @(posedge Clk) begin
        if (!Rst_n) begin
            m     = '{mr: 0, alu: 0, a: 0, rw: 0, m2r: 0, lu: 0, bs: 0};
            m_cnt = 32'd0;
        end else if (Flush) begin
            m = '{mr: 0, alu: 0, a: 0, rw: 0, m2r: 0, lu: 0, bs: 0};
        end else if (!Stall) begin
            m = '{mr: MemoryRead_in, alu: ALUResult_in, a: AddressSelected_in,
                  rw: RegWrite_in, m2r: MemToReg_in, lu: LoadUnsigned_in, bs: BitSel_in};
            if (RegWrite_in) m_cnt = m_cnt + 32'd1;
        end
    end

    always @(negedge Clk) begin
        if (cmp_en) begin
            check("model_WriteData", WriteData, exp_wd(m));
            check("model_WriteReg", {27'd0, WriteReg}, {27'd0, m.a});
            check("model_RegWrite_wb", {31'd0, RegWrite_wb}, {31'd0, m.rw && (m.a != 5'd0)});
            check("model_Fwd_Valid", {31'd0, Fwd_Valid}, {31'd0, m.rw && (m.a != 5'd0)});
            check("model_Fwd_Reg", {27'd0, Fwd_Reg}, {27'd0, m.a});
`ifdef RETIRE_CNT_EN
            check("model_RetireCount", RetireCount, m_cnt);
`endif
        end
    end

    task automatic drive(input logic [31:0] alu, input logic [31:0] mr, input logic [4:0] a,
                         input logic rw, input logic m2r, input logic [1:0] bs, input logic lu);
        ALUResult_in = alu; MemoryRead_in = mr; AddressSelected_in = a;
        RegWrite_in = rw; MemToReg_in = m2r; BitSel_in = bs; LoadUnsigned_in = lu;
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    localparam logic [31:0] MR = 32'h80F0_7F85;

    initial begin
        Rst_n = 1'b0; Stall = 1'b1; Flush = 1'b1;
        drive(32'hDEAD_BEEF, 32'hFFFF_FFFF, 5'd31, 1'b1, 1'b1, 2'b10, 1'b1);
        step();
        cmp_en = 1'b1;
        step();
        check("rst_WriteData", WriteData, 32'h0);
        check("rst_WriteReg", {27'd0, WriteReg}, 32'd0);
        check("rst_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd0);
        check("rst_Fwd_Valid", {31'd0, Fwd_Valid}, 32'd0);

        Rst_n = 1'b1; Stall = 1'b0; Flush = 1'b0;
        drive(32'h0000_1234, 32'h0, 5'd8, 1'b1, 1'b0, 2'b00, 1'b0);
        step();
        check("alu_WriteData", WriteData, 32'h0000_1234);
        check("alu_WriteReg", {27'd0, WriteReg}, 32'd8);
        check("alu_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd1);

        drive(32'h100, MR, 5'd2, 1'b1, 1'b1, 2'b10, 1'b0); step();
        check("lb_off0", WriteData, 32'hFFFF_FF85);
        drive(32'h101, MR, 5'd2, 1'b1, 1'b1, 2'b10, 1'b0); step();
        check("lb_off1", WriteData, 32'h0000_007F);
        drive(32'h103, MR, 5'd2, 1'b1, 1'b1, 2'b10, 1'b1); step();
        check("lbu_off3", WriteData, 32'h0000_0080);
        drive(32'h102, MR, 5'd2, 1'b1, 1'b1, 2'b01, 1'b1); step();
        check("lhu_off2", WriteData, 32'h0000_80F0);
        drive(32'h102, MR, 5'd2, 1'b1, 1'b1, 2'b01, 1'b0); step();
        check("lh_off2", WriteData, 32'hFFFF_80F0);
        drive(32'h103, MR, 5'd2, 1'b1, 1'b1, 2'b01, 1'b1); step();
        check("lhu_off3", WriteData, 32'h0000_80F0);
        drive(32'h101, MR, 5'd2, 1'b1, 1'b1, 2'b01, 1'b0); step();
        check("lh_off1", WriteData, 32'h0000_7F85);
        drive(32'h102, MR, 5'd2, 1'b1, 1'b1, 2'b00, 1'b0); step();
        check("lw_00", WriteData, 32'h80F0_7F85);
        drive(32'h103, MR, 5'd2, 1'b1, 1'b1, 2'b11, 1'b1); step();
        check("lw_11", WriteData, 32'h80F0_7F85);

        drive(32'd5, MR, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0); step();
        check("zero_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd0);
        check("zero_Fwd_Valid", {31'd0, Fwd_Valid}, 32'd0);
        check("zero_WriteData", WriteData, 32'd5);

        drive(32'h0000_AAAA, 32'h0, 5'd3, 1'b1, 1'b0, 2'b00, 1'b0); step();
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h100 + i, 32'h5555_0000 + i, 5'd10 + 5'(i), 1'b1, 1'b0, 2'b00, 1'b0);
            step();
            check("stall_WriteData", WriteData, 32'h0000_AAAA);
            check("stall_WriteReg", {27'd0, WriteReg}, 32'd3);
        end
        Stall = 1'b0;
        drive(32'h0000_BBBB, 32'h0, 5'd9, 1'b1, 1'b0, 2'b00, 1'b0); step();
        check("unstall_WriteData", WriteData, 32'h0000_BBBB);
        check("unstall_WriteReg", {27'd0, WriteReg}, 32'd9);

        Stall = 1'b1; Flush = 1'b1; step();
        check("flush_stall_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd0);
        Flush = 1'b0; Stall = 1'b0;
        drive(32'h0000_0444, 32'h0, 5'd4, 1'b1, 1'b0, 2'b00, 1'b0); step();
        Stall = 1'b1; Rst_n = 1'b0; step();
        check("rst_stall_WriteReg", {27'd0, WriteReg}, 32'd0);
        check("rst_stall_WriteData", WriteData, 32'd0);
        check("rst_stall_RegWrite_wb", {31'd0, RegWrite_wb}, 32'd0);
        Rst_n = 1'b1; Stall = 1'b0;

`ifdef RETIRE_CNT_EN
        for (int i = 0; i < 4; i++) begin
            drive(32'h10 + i, 32'h0, 5'd5, 1'b1, 1'b0, 2'b00, 1'b0); step();
        end
        Flush = 1'b1; step(); Flush = 1'b0;
        Stall = 1'b1; step(); step(); Stall = 1'b0;
        drive(32'h0, 32'h0, 5'd5, 1'b0, 1'b0, 2'b00, 1'b0); step();
        check("retire_count_4", RetireCount, 32'd4);
        force dut.r_retire_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_retire_cnt;
        drive(32'h1, 32'h0, 5'd0, 1'b1, 1'b0, 2'b00, 1'b0); step();
        check("retire_wrap", RetireCount, 32'd0);
`endif

        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 2'b00, 1'b0);
        step();
        @(negedge Clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
